// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_run_ctrl
//  Description : Run-control sequencer for the single-cycle core. Owns the
//                datapath reset, gates every architectural update through
//                CORE_EN, accepts HALT/RUN/STEP/RESET commands, stops on a PC
//                breakpoint or EBREAK, and counts retired instructions.
//  Ports       :
//    CLK, RST               clock and synchronous active-high reset
//    CMD_VALID, CMD         command handshake input (00 HALT, 01 RUN,
//                           10 STEP, 11 RESET)
//    CMD_READY              command accepted when CMD_VALID && CMD_READY
//    PC, INS                observed datapath PC and fetched instruction
//    BP_EN, BP_ADDR         breakpoint enable and address
//    CORE_RST, CORE_EN      datapath reset and architectural-update enable
//    HALTED, HALT_CAUSE     halt status and reason (00 none, 01 cmd,
//                           10 breakpoint, 11 EBREAK)
//    STEP_DONE              one-cycle pulse after a stepped instruction
//    INSTRET                retired-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module core_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter bit AUTO_RUN   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  input  logic [1:0]  CMD,
  output logic        CMD_READY,
  input  logic [31:0] PC,
  input  logic [31:0] INS,
  input  logic        BP_EN,
  input  logic [31:0] BP_ADDR,
  output logic        CORE_RST,
  output logic        CORE_EN,
  output logic        HALTED,
  output logic [1:0]  HALT_CAUSE,
  output logic        STEP_DONE,
  output logic [31:0] INSTRET
);

  localparam int          CNT_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [31:0] EBREAK_INS = 32'h0010_0073;

  localparam logic [1:0]  CMD_HALT   = 2'b00;
  localparam logic [1:0]  CMD_RUN    = 2'b01;
  localparam logic [1:0]  CMD_STEP   = 2'b10;
  localparam logic [1:0]  CMD_RESET  = 2'b11;

  localparam logic [1:0]  CAUSE_NONE = 2'b00;
  localparam logic [1:0]  CAUSE_CMD  = 2'b01;
  localparam logic [1:0]  CAUSE_BP   = 2'b10;
  localparam logic [1:0]  CAUSE_EBRK = 2'b11;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rst_cnt;
  logic             skip;
  logic [1:0]       halt_cause;
  logic             step_done;
  logic [31:0]      instret;

  logic             bp_hit;
  logic             eb_hit;
  logic             hit;
  logic             cmd_acc;

  // Hit detection is suppressed for the first RUN cycle (skip) so that a
  // resume from a breakpoint/EBREAK executes the instruction at that PC.
  always_comb begin
    bp_hit    = BP_EN && (PC == BP_ADDR);
    eb_hit    = (INS == EBREAK_INS);
    hit       = (state == ST_RUN) && !skip && (bp_hit || eb_hit);
    CORE_EN   = (state == ST_STEP) || ((state == ST_RUN) && !hit);
    CMD_READY = (state == ST_HALTED) || (state == ST_RUN);
    cmd_acc   = CMD_VALID && CMD_READY;
  end

  assign CORE_RST   = (state == ST_RST_HOLD);
  assign HALTED     = (state == ST_HALTED);
  assign HALT_CAUSE = halt_cause;
  assign STEP_DONE  = step_done;
  assign INSTRET    = instret;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_RST_HOLD;
      rst_cnt    <= '0;
      skip       <= 1'b0;
      halt_cause <= CAUSE_NONE;
      step_done  <= 1'b0;
      instret    <= '0;
    end else begin
      step_done <= 1'b0;
      if (CORE_EN) begin
        instret <= instret + 32'd1;
      end

      case (state)
        ST_RST_HOLD: begin
          if (rst_cnt == CNT_LAST) begin
            rst_cnt <= '0;
            if (AUTO_RUN) begin
              state <= ST_RUN;
            end else begin
              state <= ST_HALTED;
            end
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_HALTED: begin
          if (cmd_acc) begin
            case (CMD)
              CMD_RUN: begin
                state <= ST_RUN;
                skip  <= 1'b1;
              end
              CMD_STEP: begin
                state <= ST_STEP;
              end
              CMD_RESET: begin
                state      <= ST_RST_HOLD;
                rst_cnt    <= '0;
                skip       <= 1'b0;
                halt_cause <= CAUSE_NONE;
                instret    <= '0;
              end
              default: begin
                // HALT while halted has no effect
              end
            endcase
          end
        end

        ST_RUN: begin
          skip <= 1'b0;
          // Priority: RESET over hit over HALT. The reset entry overrides the
          // retire increment above because it is the later assignment.
          if (cmd_acc && (CMD == CMD_RESET)) begin
            state      <= ST_RST_HOLD;
            rst_cnt    <= '0;
            halt_cause <= CAUSE_NONE;
            instret    <= '0;
          end else if (hit) begin
            state      <= ST_HALTED;
            halt_cause <= bp_hit ? CAUSE_BP : CAUSE_EBRK;
          end else if (cmd_acc && (CMD == CMD_HALT)) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_CMD;
          end
        end

        ST_STEP: begin
          state      <= ST_HALTED;
          halt_cause <= CAUSE_CMD;
          step_done  <= 1'b1;
        end

        default: begin
          state <= ST_RST_HOLD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_run_ctrl
//  Description : Self-checking bench for core_run_ctrl: directed scenarios
//                followed by a randomized phase, all compared against a
//                cycle-level behavioural model of the run-control rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int RC = 2;

  // model modes
  localparam int M_RH = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        core_rst;
  logic        core_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        step_done;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_mode;
  int          m_cnt;
  bit          m_skip;
  logic [1:0]  m_cause;
  bit          m_sdone;
  logic [31:0] m_ret;

  // datapath stub controls
  bit          manual_pc = 1'b0;
  bit          eb_en = 1'b0;
  logic [31:0] eb_addr = 32'h0;

  core_run_ctrl #(.RST_CYCLES(RC), .AUTO_RUN(1'b0)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD(cmd), .CMD_READY(cmd_ready),
    .PC(pc), .INS(ins), .BP_EN(bp_en), .BP_ADDR(bp_addr),
    .CORE_RST(core_rst), .CORE_EN(core_en), .HALTED(halted),
    .HALT_CAUSE(halt_cause), .STEP_DONE(step_done), .INSTRET(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RH; m_cnt = 0; m_skip = 0; m_cause = 2'b00; m_sdone = 0; m_ret = 32'h0;
  endtask

  // One clock cycle: compare outputs against the model, advance the model by
  // the run-control rules, and move the datapath stub.
  task automatic tick();
    bit acc, hit, en, ready, was_rst, dut_en;
    int n_mode, n_cnt;
    bit n_skip, n_sdone;
    logic [1:0] n_cause;
    logic [31:0] n_ret;
    #1;
    ready = (m_mode == M_HALT) || (m_mode == M_RUN);
    acc   = cmd_valid && ready;
    hit   = (m_mode == M_RUN) && !m_skip && ((bp_en && pc == bp_addr) || ins == EBREAK);
    en    = (m_mode == M_STEP) || ((m_mode == M_RUN) && !hit);
    chk("core_rst",   core_rst,   m_mode == M_RH);
    chk("core_en",    core_en,    en);
    chk("cmd_ready",  cmd_ready,  ready);
    chk("halted",     halted,     m_mode == M_HALT);
    chk("halt_cause", halt_cause, m_cause);
    chk("step_done",  step_done,  m_sdone);
    chk("instret",    instret,    m_ret);
    dut_en  = core_en;
    was_rst = (m_mode == M_RH);

    n_mode = m_mode; n_cnt = m_cnt; n_skip = m_skip; n_cause = m_cause;
    n_sdone = 0; n_ret = en ? m_ret + 32'd1 : m_ret;
    if (rst) begin
      n_mode = M_RH; n_cnt = 0; n_skip = 0; n_cause = 0; n_ret = 0;
    end else begin
      case (m_mode)
        M_RH: begin
          if (m_cnt == RC - 1) begin n_mode = M_HALT; n_cnt = 0; end
          else n_cnt = m_cnt + 1;
        end
        M_HALT: if (acc) begin
          if (cmd == 2'b01) begin n_mode = M_RUN; n_skip = 1; end
          else if (cmd == 2'b10) n_mode = M_STEP;
          else if (cmd == 2'b11) begin
            n_mode = M_RH; n_cnt = 0; n_skip = 0; n_cause = 0; n_ret = 0;
          end
        end
        M_RUN: begin
          n_skip = 0;
          if (acc && cmd == 2'b11) begin
            n_mode = M_RH; n_cnt = 0; n_cause = 0; n_ret = 0;
          end else if (hit) begin
            n_mode = M_HALT;
            n_cause = (bp_en && pc == bp_addr) ? 2'b10 : 2'b11;
          end else if (acc && cmd == 2'b00) begin
            n_mode = M_HALT; n_cause = 2'b01;
          end
        end
        default: begin
          n_mode = M_HALT; n_cause = 2'b01; n_sdone = 1;
        end
      endcase
    end

    @(posedge clk);
    #1;
    m_mode = n_mode; m_cnt = n_cnt; m_skip = n_skip; m_cause = n_cause;
    m_sdone = n_sdone; m_ret = n_ret;
    if (!manual_pc) begin
      if (was_rst) pc = 32'h0;
      else if (dut_en) pc = pc + 32'd4;
      ins = (eb_en && pc == eb_addr) ? EBREAK : NOP;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_halted(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    chk("reach_halted", halted, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; pc = 32'h0; ins = NOP;
    bp_en = 1'b0; bp_addr = 32'h10;

    // ---- reset: RST high 3 cycles ----
    @(posedge clk); #1; model_reset(); @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1 chk("rst_seq0", core_rst, 1'b1);
    tick();
    #1 chk("rst_seq1", core_rst, 1'b1);
    tick();
    #1;
    chk("rst_done_halted", halted, 1'b1);
    chk("rst_done_cause", halt_cause, 2'b00);
    chk("rst_done_instret", instret, 32'd0);
    chk("rst_done_en", core_en, 1'b0);

    // ---- run / halt ----
    issue(2'b01);
    repeat (10) tick();
    issue(2'b00);
    tick();
    chk("runhalt_instret", instret, 32'd11);
    chk("runhalt_halted", halted, 1'b1);
    chk("runhalt_cause", halt_cause, 2'b01);

    // ---- breakpoint at 0x10 ----
    issue(2'b11);
    run_until_halted(10);
    bp_en = 1'b1; bp_addr = 32'h10;
    issue(2'b01);
    run_until_halted(20);
    chk("bp_cause", halt_cause, 2'b10);
    chk("bp_instret", instret, 32'd4);
    chk("bp_pc", pc, 32'h10);
    issue(2'b01);
    #1 chk("bp_skip_en", core_en, 1'b1);
    tick(); tick();
    issue(2'b00);
    tick();
    chk("bp_resume_pc", pc, 32'h1C);

    // ---- step at a breakpoint ----
    issue(2'b11);
    run_until_halted(10);
    issue(2'b01);
    run_until_halted(20);
    chk("step_pre_pc", pc, 32'h10);
    issue(2'b10);
    #1;
    chk("step_ready", cmd_ready, 1'b0);
    chk("step_en", core_en, 1'b1);
    tick();
    #1;
    chk("step_done", step_done, 1'b1);
    chk("step_halted", halted, 1'b1);
    chk("step_instret", instret, 32'd5);
    chk("step_cause", halt_cause, 2'b01);
    tick();
    #1 chk("step_done_clr", step_done, 1'b0);

    // ---- EBREAK at 0x8 ----
    bp_en = 1'b0;
    eb_en = 1'b1; eb_addr = 32'h8;
    issue(2'b11);
    run_until_halted(10);
    issue(2'b01);
    run_until_halted(20);
    chk("eb_cause", halt_cause, 2'b11);
    chk("eb_instret", instret, 32'd2);

    // ---- reset mid-run ----
    issue(2'b01);
    tick(); tick();
    issue(2'b11);
    #1;
    chk("rstcmd_core_rst", core_rst, 1'b1);
    chk("rstcmd_instret", instret, 32'd0);
    chk("rstcmd_cause", halt_cause, 2'b00);
    tick();
    #1 chk("rstcmd_core_rst1", core_rst, 1'b1);
    tick();
    #1 chk("rstcmd_halted", halted, 1'b1);

    // ---- INSTRET wrap ----
    eb_en = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    tick();
    release dut.instret;
    #1 chk("wrap_pre", instret, 32'hFFFF_FFFF);
    issue(2'b01);
    issue(2'b00);
    tick();
    chk("wrap_instret", instret, 32'd0);

    // ---- randomized phase ----
    manual_pc = 1'b1;
    bp_addr = 32'h10;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 60) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd       = 2'($urandom_range(0, 3));
      if (cmd == 2'b11 && $urandom_range(0, 3) != 0) cmd = 2'b01;
      pc        = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      bp_en     = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0:       ins = EBREAK;
        1:       ins = $urandom;
        default: ins = NOP;
      endcase
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run-control sequencer for the single-cycle core. It owns the datapath's reset, applies the reset on its own schedule, and gates every architectural state update (PC, register write, memory write) through one enable. It accepts HALT / RUN / STEP / RESET commands from the debug or loader side, stops the core on a PC breakpoint or an EBREAK instruction, and counts retired instructions. It sits between the top-level clock/reset and the datapath, and observes the datapath's PC and INS.

## Interface

Parameters:
- RST_CYCLES, default 2: number of cycles CORE_RST is held per reset sequence (≥1).
- AUTO_RUN, default 0: 1 = go to RUN after the reset sequence; 0 = go to HALTED.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset of this block.
- CMD_VALID  in  1  command present.
- CMD  in  2  command code: 00 HALT, 01 RUN, 10 STEP, 11 RESET.
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY at a rising edge.
- PC  in  32  current datapath PC.
- INS  in  32  current instruction fetched at PC.
- BP_EN  in  1  breakpoint enable.
- BP_ADDR  in  32  breakpoint PC.
- CORE_RST  out  1  reset to the datapath (its RST).
- CORE_EN  out  1  qualifies PC update, RegWEN and MEMW in the datapath; 0 = core frozen.
- HALTED  out  1  state == HALTED.
- HALT_CAUSE  out  2  00 reset/none, 01 HALT command, 10 breakpoint, 11 EBREAK.
- STEP_DONE  out  1  one-cycle pulse after a STEP instruction retires.
- INSTRET  out  32  retired-instruction count.

## Operation

- States:
  - RST_HOLD: CORE_RST=1, CORE_EN=0, CMD_READY=0. Internal counter runs 0..RST_CYCLES-1, then the block moves to RUN if AUTO_RUN, else to HALTED.
  - HALTED: CORE_EN=0, CMD_READY=1.
    - RUN → RUN and set the skip flag.
    - STEP → STEP.
    - RESET → RST_HOLD.
    - HALT → ignored.
  - RUN: CMD_READY=1.
    - hit = (BP_EN && PC==BP_ADDR) || INS==32'h00100073, evaluated only when the skip flag is 0.
    - On a hit: CORE_EN=0 this cycle; next state HALTED; HALT_CAUSE=10 for a breakpoint, 11 for EBREAK. Breakpoint wins if both are true.
    - Otherwise CORE_EN=1.
    - The skip flag clears after any RUN cycle.
    - HALT accepted → the current cycle still executes (CORE_EN per the rules above); next state HALTED, HALT_CAUSE=01.
    - RESET accepted → next state RST_HOLD; the current cycle still executes.
    - RUN or STEP while in RUN → accepted and ignored.
  - STEP: CORE_EN=1 for exactly one cycle regardless of breakpoint or EBREAK. CMD_READY=0. Next state HALTED, STEP_DONE=1 for the following cycle, HALT_CAUSE=01.
- Entering RST_HOLD (via RST or the RESET command) clears INSTRET, HALT_CAUSE and the skip flag.
- INSTRET increments by 1 on every rising edge where CORE_EN=1 and the block is not in reset. It wraps 0xFFFFFFFF → 0.
- The skip flag exists so that RUN resumes past a breakpoint or EBREAK at the current PC without re-triggering. It covers exactly the first RUN cycle.
- A hit and an accepted HALT in the same RUN cycle: the hit cause (10/11) is recorded and CORE_EN=0.
- An accepted RESET in the same cycle as a hit: the next state is RST_HOLD and HALT_CAUSE=00.

## Timing

- Reset values (after a rising edge with RST=1):
  - state = RST_HOLD, CORE_RST=1, CORE_EN=0, CMD_READY=0.
  - HALTED=0, HALT_CAUSE=00, STEP_DONE=0, INSTRET=0.
- RST held high keeps the block in RST_HOLD with the counter at 0.
- Reset sequence length: exactly RST_CYCLES cycles with CORE_RST=1 after RST deasserts (or after the RESET command is accepted). The next cycle is HALTED or RUN.
- CORE_EN is combinational from the registered state, the skip flag, PC, INS, BP_EN and BP_ADDR. It does not depend on CMD_VALID.
- All other outputs are registered or decoded from the registered state.
- Command latency: the new state is effective on the cycle after acceptance.
- RUN accepted in HALTED: the first instruction executes in the next cycle.
- STEP accepted in HALTED: one instruction executes in the next cycle (STEP state). HALTED=1 and STEP_DONE=1 follow one cycle later.
- Breakpoint/EBREAK: HALTED=1 the cycle after the hit. The PC stays at the hit address and INSTRET does not count the hit cycle.

## Test plan

- Reset: RST high 3 cycles, then low, RST_CYCLES=2, AUTO_RUN=0 → CORE_RST=1 for 2 cycles after deassert, then HALTED=1, HALT_CAUSE=00, INSTRET=0, CORE_EN=0.
- Run/halt: RUN accepted, 10 RUN cycles, then HALT accepted → INSTRET=11 (the HALT-accept cycle executes), HALTED=1, HALT_CAUSE=01.
- Breakpoint:
  - BP_EN=1, BP_ADDR=0x10; RUN with PC advancing by 4 from 0 → CORE_EN=0 at PC=0x10, HALTED next cycle, HALT_CAUSE=10, INSTRET=4.
  - RUN again → CORE_EN=1 at PC=0x10 (skip), execution continues.
- EBREAK: INS=0x00100073 at PC=0x8 during RUN → halt, HALT_CAUSE=11, INSTRET=2.
- STEP at a breakpoint: halted at PC=0x10 with BP_EN=1, STEP → exactly one CORE_EN=1 cycle, STEP_DONE pulse, HALTED, INSTRET +1, CMD_READY=0 during STEP.
- Reset mid-run and wrap:
  - RESET accepted in RUN → RST_HOLD for RST_CYCLES, INSTRET=0, HALT_CAUSE=00.
  - With INSTRET forced to 0xFFFFFFFF, one RUN cycle → INSTRET=0.
